// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg: shared encodings for the single-issue MIPS fetch front end   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam logic [2:0] PCSEL_SEQ  = 3'd0;
  localparam logic [2:0] PCSEL_BR   = 3'd1;
  localparam logic [2:0] PCSEL_J    = 3'd2;
  localparam logic [2:0] PCSEL_JR   = 3'd3;
  localparam logic [2:0] PCSEL_ERET = 3'd4;

  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/branch_target_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_target_adder: pc_plus4 + sign-extended word offset (mod 2^32)  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module branch_target_adder (
  input  logic [31:0] i_pc_plus4,
  input  logic [15:0] i_imm16,
  output logic [31:0] o_target
);

  logic [31:0] w_offset;

  assign w_offset = {{14{i_imm16[15]}}, i_imm16, 2'b00};
  assign o_target = i_pc_plus4 + w_offset;

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_sequencer: PC register, next-PC select, stall hold, retire count   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
  parameter logic [31:0] EXC_VECTOR = cpu_pkg::EXC_VECTOR,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [2:0]       pc_sel,
  input  logic             branch_taken,
  input  logic [15:0]      imm16,
  input  logic [31:0]      jt_in,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      epc_in,
  input  logic             exc_req,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc_plus4,
  output logic [3:0]       pc_hi,
  output logic             misalign,
  output logic [CNT_W-1:0] instr_count
);

  import cpu_pkg::*;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_update;
  logic [31:0]      r_pc;
  logic             r_misalign;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_br_target;
  logic [31:0]      w_next_pc;

  assign w_pc_plus4 = r_pc + 32'd4;

  branch_target_adder u_bta (
    .i_pc_plus4 (w_pc_plus4),
    .i_imm16    (imm16),
    .o_target   (w_br_target)
  );

  // Undefined selects 5-7 fall through to sequential.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (exc_req) begin
      w_next_pc = EXC_VECTOR;
    end else begin
      case (pc_sel)
        PCSEL_ERET: w_next_pc = epc_in;
        PCSEL_JR:   w_next_pc = rs_val;
        PCSEL_J:    w_next_pc = jt_in;
        PCSEL_BR:   w_next_pc = branch_taken ? w_br_target : w_pc_plus4;
        default:    w_next_pc = w_pc_plus4;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_update    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (stall) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_update = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          w_state_nxt = ST_RUN;
          w_update    = 1'b1;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_update) begin
        r_pc       <= w_next_pc;
        r_misalign <= |w_next_pc[1:0];
        r_count    <= r_count + c_cnt_one;
      end
    end
  end

  assign pc_out      = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign pc_hi       = w_pc_plus4[31:28];
  assign misalign    = r_misalign;
  assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pc_sequencer: directed vector bench for pc_sequencer               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [2:0]  pc_sel;
  logic        branch_taken;
  logic [15:0] imm16;
  logic [31:0] jt_in;
  logic [31:0] rs_val;
  logic [31:0] epc_in;
  logic        exc_req;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [3:0]  pc_hi;
  logic        misalign;
  logic [31:0] instr_count;

  int n_vec;
  int n_cmp;
  int n_err;

  typedef struct {
    logic        rst;
    logic        stall;
    logic [2:0]  sel;
    logic        bt;
    logic [15:0] imm;
    logic [31:0] jt;
    logic [31:0] rs;
    logic [31:0] epc;
    logic        exc;
    logic [31:0] exp_pc;
    logic        exp_mis;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vt[$];

  pc_sequencer #(
    .RESET_PC   (32'h0040_0000),
    .EXC_VECTOR (32'h0040_0004),
    .CNT_W      (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .pc_sel       (pc_sel),
    .branch_taken (branch_taken),
    .imm16        (imm16),
    .jt_in        (jt_in),
    .rs_val       (rs_val),
    .epc_in       (epc_in),
    .exc_req      (exc_req),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4),
    .pc_hi        (pc_hi),
    .misalign     (misalign),
    .instr_count  (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic s, logic [2:0] sel, logic bt, logic [15:0] imm,
                              logic [31:0] jt, logic [31:0] rs, logic [31:0] epc, logic exc,
                              logic [31:0] epc_exp, logic mis, logic [31:0] cnt);
    vec_t v;
    v.rst = r; v.stall = s; v.sel = sel; v.bt = bt; v.imm = imm;
    v.jt = jt; v.rs = rs; v.epc = epc; v.exc = exc;
    v.exp_pc = epc_exp; v.exp_mis = mis; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic cmp32(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec%0d %s: got %h expected %h", n_vec, name, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    logic [31:0] exp_p4;
    rst = v.rst; stall = v.stall; pc_sel = v.sel; branch_taken = v.bt; imm16 = v.imm;
    jt_in = v.jt; rs_val = v.rs; epc_in = v.epc; exc_req = v.exc;
    @(posedge clk);
    #1;
    n_vec++;
    exp_p4 = v.exp_pc + 32'd4;
    cmp32("pc_out", pc_out, v.exp_pc);
    cmp32("misalign", {31'd0, misalign}, {31'd0, v.exp_mis});
    cmp32("instr_count", instr_count, v.exp_cnt);
    cmp32("pc_plus4", pc_plus4, exp_p4);
    cmp32("pc_hi", {28'd0, pc_hi}, {28'd0, exp_p4[31:28]});
  endtask

  initial begin
    n_vec = 0; n_cmp = 0; n_err = 0;
    rst = 1'b1; stall = 1'b0; pc_sel = 3'd0; branch_taken = 1'b0; imm16 = 16'h0;
    jt_in = 32'h0; rs_val = 32'h0; epc_in = 32'h0; exc_req = 1'b0;

    //              rst   stall sel   bt    imm       jt            rs            epc           exc   pc            mis   cnt
    vt.push_back(mk(1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0040_0000, 1'b0, 32'd0));
    vt.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0040_0004, 1'b0, 32'd1));
    vt.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0040_0008, 1'b0, 32'd2));
    vt.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0040_000C, 1'b0, 32'd3));
    vt.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0040_0010, 1'b0, 32'd4));
    vt.push_back(mk(1'b0, 1'b0, 3'd1, 1'b1, 16'hFFFC, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0040_0004, 1'b0, 32'd5));
    vt.push_back(mk(1'b0, 1'b0, 3'd2, 1'b0, 16'h0000, 32'h0040_0010, 32'h0,       32'h0,        1'b0, 32'h0040_0010, 1'b0, 32'd6));
    vt.push_back(mk(1'b0, 1'b0, 3'd1, 1'b0, 16'hFFFC, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0040_0014, 1'b0, 32'd7));
    vt.push_back(mk(1'b0, 1'b0, 3'd2, 1'b0, 16'h0000, 32'h0040_0020, 32'h0,       32'h0,        1'b0, 32'h0040_0020, 1'b0, 32'd8));
    vt.push_back(mk(1'b0, 1'b0, 3'd2, 1'b0, 16'h0000, 32'h0040_0100, 32'h0,       32'h0,        1'b0, 32'h0040_0100, 1'b0, 32'd9));
    vt.push_back(mk(1'b0, 1'b0, 3'd1, 1'b1, 16'h0010, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0040_0144, 1'b0, 32'd10));
    vt.push_back(mk(1'b0, 1'b0, 3'd3, 1'b0, 16'h0000, 32'h0,        32'hFFFF_FFFC, 32'h0,       1'b0, 32'hFFFF_FFFC, 1'b0, 32'd11));
    vt.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0000_0000, 1'b0, 32'd12));
    vt.push_back(mk(1'b0, 1'b0, 3'd2, 1'b0, 16'h0000, 32'h0040_0200, 32'h0,       32'h0,        1'b0, 32'h0040_0200, 1'b0, 32'd13));
    vt.push_back(mk(1'b0, 1'b0, 3'd3, 1'b0, 16'h0000, 32'h0,        32'h0040_0300, 32'h0,       1'b1, 32'h0040_0004, 1'b0, 32'd14));
    vt.push_back(mk(1'b0, 1'b0, 3'd4, 1'b0, 16'h0000, 32'h0,        32'h0,        32'h0040_0050, 1'b0, 32'h0040_0050, 1'b0, 32'd15));
    vt.push_back(mk(1'b0, 1'b0, 3'd3, 1'b0, 16'h0000, 32'h0,        32'h0040_0302, 32'h0,       1'b0, 32'h0040_0302, 1'b1, 32'd16));
    vt.push_back(mk(1'b0, 1'b0, 3'd5, 1'b1, 16'h0040, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0040_0306, 1'b1, 32'd17));
    vt.push_back(mk(1'b0, 1'b0, 3'd7, 1'b1, 16'h0040, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0040_030A, 1'b1, 32'd18));
    vt.push_back(mk(1'b0, 1'b0, 3'd4, 1'b0, 16'h0000, 32'h0,        32'h0,        32'h0040_0060, 1'b0, 32'h0040_0060, 1'b0, 32'd19));

    foreach (vt[i]) apply(vt[i]);

    // Four stalled edges with a jump pending, then release into the jump.
    for (int k = 0; k < 4; k++)
      apply(mk(1'b0, 1'b1, 3'd2, 1'b0, 16'h0, 32'h0040_0400, 32'h0, 32'h0, 1'b0, 32'h0040_0060, 1'b0, 32'd19));
    apply(mk(1'b0, 1'b0, 3'd2, 1'b0, 16'h0, 32'h0040_0200, 32'h0, 32'h0, 1'b0, 32'h0040_0200, 1'b0, 32'd20));

    // Stall beats a simultaneous exception; exception taken once stall drops.
    apply(mk(1'b0, 1'b1, 3'd0, 1'b0, 16'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0040_0200, 1'b0, 32'd20));
    apply(mk(1'b0, 1'b0, 3'd0, 1'b0, 16'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0040_0004, 1'b0, 32'd21));

    // Misaligned PC, then reset lands in the middle of a two-cycle stall.
    apply(mk(1'b0, 1'b0, 3'd3, 1'b0, 16'h0, 32'h0, 32'h0040_0302, 32'h0, 1'b0, 32'h0040_0302, 1'b1, 32'd22));
    apply(mk(1'b0, 1'b1, 3'd0, 1'b0, 16'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0040_0302, 1'b1, 32'd22));
    apply(mk(1'b1, 1'b1, 3'd0, 1'b0, 16'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0040_0000, 1'b0, 32'd0));
    apply(mk(1'b0, 1'b0, 3'd0, 1'b0, 16'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0040_0004, 1'b0, 32'd1));

    // Reset overrides a concurrent exception and redirect.
    apply(mk(1'b1, 1'b0, 3'd3, 1'b0, 16'h0, 32'h0, 32'h0040_0700, 32'h0, 1'b1, 32'h0040_0000, 1'b0, 32'd0));
    apply(mk(1'b0, 1'b0, 3'd0, 1'b0, 16'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0040_0004, 1'b0, 32'd1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter register and next-PC selection stage for the 54-instruction single-issue MIPS core.
- Supplies the fetch address each cycle.
- Sends PC+4 bits [31:28] downstream to the jump-target concatenation stage, and consumes the 32-bit jump target that stage returns.
- Also handles stall hold, exception entry/return redirection, and a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0040_0004, PC loaded on exception entry.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold PC and counter (multi-cycle mult/div busy)
- pc_sel  input  3  next-PC source: 0 seq, 1 branch, 2 jump, 3 jr/jalr, 4 eret; 5-7 treated as 0
- branch_taken  input  1  qualifies pc_sel=1
- imm16  input  16  branch offset field
- jt_in  input  32  jump target from the concatenation stage
- rs_val  input  32  register target for jr/jalr
- epc_in  input  32  EPC from CP0, used for eret
- exc_req  input  1  syscall/break/teq exception entry request
- pc_out  output  32  current fetch address
- pc_plus4  output  32  pc_out+4, combinational; also the jal/jalr link value
- pc_hi  output  4  pc_plus4[31:28], fed to the concatenation stage
- misalign  output  1  registered flag: last loaded PC had bits [1:0] != 0
- instr_count  output  CNT_W  instructions retired since reset

Behaviour:
- Reset (rst=1 at a clk edge):
  - pc_out = RESET_PC, instr_count = 0, misalign = 0.
  - Reset wins over every other input.
  - A reset asserted mid-stall clears the state to RUN.
- State machine: RUN, HOLD.
  - RUN -> HOLD when stall=1 at an edge; PC is not updated on that edge.
  - HOLD -> RUN on the first edge with stall=0; that edge performs a normal update using the inputs present on that cycle.
  - In HOLD, pc_out and instr_count are frozen.
- Next-PC, priority high to low:
  1. exc_req=1 -> EXC_VECTOR. exc_req is ignored while stall=1 (the CP0 side re-asserts it).
  2. pc_sel=4 -> epc_in.
  3. pc_sel=3 -> rs_val.
  4. pc_sel=2 -> jt_in.
  5. pc_sel=1 and branch_taken=1 -> pc_plus4 + ({{14{imm16[15]}}, imm16, 2'b00}), computed modulo 2^32.
  6. Otherwise -> pc_plus4.
- Every arithmetic result wraps modulo 2^32; PC 32'hFFFF_FFFC sequential -> 32'h0000_0000. No fault is raised.
- There is no branch delay slot; the redirect takes effect on the next edge (latency 1 cycle).
- jt_in is accepted as-is; the concatenation stage is responsible for forming {pc_hi, index, 2'b00}.
- misalign is registered alongside pc_out as (next_pc[1:0] != 0). The PC value is still loaded unmodified. Only rs_val or epc_in can produce a misaligned PC.
- instr_count:
  - Increments by 1 on every non-reset, non-stalled edge, including the exception-entry edge.
  - Wraps at 2^CNT_W - 1 -> 0.
- Simultaneous stall and exc_req: stall wins; nothing changes.
- All outputs except pc_plus4 and pc_hi are driven from flops.

Decomposition:
- Shared package cpu_pkg:
  - pc_sel encodings PCSEL_SEQ/BR/J/JR/ERET.
  - RESET_PC and EXC_VECTOR constants.
  - State encoding ST_RUN/ST_HOLD.
- Natural sub-module: branch_target_adder, which computes pc_plus4 + sign-extended imm16<<2 and is purely combinational.
- Next-PC mux and registers stay in pc_sequencer.

Test Plan:
1. Reset then 3 free-running cycles, pc_sel=0 -> pc_out 0x00400000, 0x00400004, 0x00400008, 0x0040000C; instr_count 0..3.
2. At pc_out=0x00400010: pc_sel=1, branch_taken=1, imm16=0xFFFC -> next pc_out 0x00400004. With branch_taken=0 -> 0x00400014.
3. pc_out=0x00400020: pc_sel=2, jt_in=0x00400100 -> 0x00400100; check pc_hi=4'h0. Sequential wrap from 0xFFFFFFFC -> 0x00000000.
4. stall=1 for 4 cycles with pc_sel=2 applied -> pc_out and instr_count unchanged. Stall drops with pc_sel=2, jt_in=0x00400200 -> 0x00400200 on the next edge.
5. exc_req=1 together with pc_sel=3, rs_val=0x00400300 -> pc_out 0x00400004. Then pc_sel=4, epc_in=0x00400050 -> 0x00400050.
6. pc_sel=3, rs_val=0x00400302 -> pc_out 0x00400302, misalign=1. rst asserted during a 2-cycle stall -> pc_out 0x00400000, instr_count 0, misalign 0, state RUN.
